// File: rtl/lamp_sequence_monitor.sv
// lamp_sequence_monitor: locks onto the RED->GREEN->YELLOW lamp cycle, checks dwell bounds and latches the first fault
module lamp_sequence_monitor #(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [0:2]       light,
  input  logic             clear_fault,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [1:0]       phase,
  output logic             locked,
  output logic [CNT_W-1:0] cycle_count
);
  localparam int DW = $clog2(MAX_DWELL + 1);
  localparam logic [DW-1:0] MIN_D = DW'(MIN_DWELL);
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DWELL);
  localparam logic [0:2] RED = 3'b100, GREEN = 3'b010, YELLOW = 3'b001;
  typedef enum logic [2:0] {INIT, RUN_RED, RUN_GREEN, RUN_YELLOW, FAULT} state_t;
  state_t state_q, state_d, nxt_state;
  logic [DW-1:0] dwell_q, dwell_d;
  logic fault_q, fault_d, locked_q, locked_d;
  logic [2:0] code_q, code_d, code;
  logic [1:0] phase_q, phase_d, nxt_phase;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:2] cur, nxt;
  logic one_hot;
  // decode the expected current and successor colour and the highest-priority fault of this sample
  always_comb begin
    cur = state_q == RUN_RED ? RED : state_q == RUN_GREEN ? GREEN : YELLOW;
    nxt = state_q == RUN_RED ? GREEN : state_q == RUN_GREEN ? YELLOW : RED;
    nxt_state = state_q == RUN_RED ? RUN_GREEN : state_q == RUN_GREEN ? RUN_YELLOW : RUN_RED;
    nxt_phase = state_q == RUN_RED ? 2'd2 : state_q == RUN_GREEN ? 2'd3 : 2'd1;
    one_hot = light == RED || light == GREEN || light == YELLOW;
    code = !one_hot ? 3'd1 :
           (light != cur && light != nxt) ? 3'd2 :
           (light == nxt && dwell_q < MIN_D) ? 3'd3 :
           (light == cur && dwell_q == MAX_D) ? 3'd4 : 3'd0;
  end
  // next-state and registered-output logic; FAULT freezes everything until cleared
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    fault_d = fault_q;
    code_d = code_q;
    phase_d = phase_q;
    locked_d = locked_q;
    cnt_d = cnt_q;
    if (state_q == INIT) begin
      if (light == RED) begin
        state_d = RUN_RED;
        dwell_d = DW'(1);
        locked_d = 1'b1;
        phase_d = 2'd1;
      end
    end else if (state_q == FAULT) begin
      if (clear_fault) begin
        state_d = INIT;
        fault_d = 1'b0;
        code_d = 3'd0;
      end
    end else if (code != 3'd0) begin
      state_d = FAULT;
      fault_d = 1'b1;
      code_d = code;
      locked_d = 1'b0;
      phase_d = 2'd0;
      dwell_d = '0;
    end else if (light == cur) begin
      dwell_d = dwell_q + DW'(1);
    end else begin
      state_d = nxt_state;
      dwell_d = DW'(1);
      phase_d = nxt_phase;
      cnt_d = state_q == RUN_YELLOW ? cnt_q + CNT_W'(1) : cnt_q;
    end
  end
  // state and output registers with synchronous reset taking priority over everything
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INIT;
      dwell_q <= '0;
      fault_q <= 1'b0;
      code_q <= 3'd0;
      phase_q <= 2'd0;
      locked_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      fault_q <= fault_d;
      code_q <= code_d;
      phase_q <= phase_d;
      locked_q <= locked_d;
      cnt_q <= cnt_d;
    end
  end
  assign fault = fault_q;
  assign fault_code = code_q;
  assign phase = phase_q;
  assign locked = locked_q;
  assign cycle_count = cnt_q;
endmodule
